// File: rtl/fir_capture.sv
// Output-side capture buffer for the FIR sample stream: drops pipeline warm-up
// samples, optionally decimates, and queues kept samples for a valid/ready consumer.
module fir_capture #(
  parameter int DW     = 10,
  parameter int DEPTH  = 8,
  parameter int WARMUP = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic [2:0]               decim,
  input  logic                     din_vld,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            dout,
  output logic                     dout_vld,
  input  logic                     dout_rdy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(WARMUP + 1);

  typedef enum logic [1:0] {IDLE, WARM, RUN} state_t;

  state_t        state;
  logic [WW-1:0] warm_cnt;
  logic [2:0]    dec_cnt;
  logic [2:0]    decim_q;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          stop_hit;
  logic          pop;
  logic          push_req;
  logic          push;

  // Full is detected via the level MSB since DEPTH is a power of two.
  always_comb begin
    stop_hit = stop && (state != IDLE);
    pop      = dout_vld && dout_rdy;
    push_req = (state == RUN) && din_vld && !stop_hit && (dec_cnt == '0);
    push     = push_req && (!level[AW] || pop);
  end

  assign dout_vld = (level != '0);
  assign dout     = dout_vld ? mem[rd_ptr] : '0;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      warm_cnt <= '0;
      dec_cnt  <= '0;
      decim_q  <= '0;
      ovf      <= 1'b0;
    end else begin
      if (push_req && !push)
        ovf <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= WARM;
            decim_q  <= decim;
            warm_cnt <= '0;
            ovf      <= 1'b0;
          end
        end
        WARM: begin
          if (stop) begin
            state <= IDLE;
          end else if (din_vld) begin
            if (warm_cnt == WW'(WARMUP - 1)) begin
              state   <= RUN;
              dec_cnt <= '0;
            end
            warm_cnt <= warm_cnt + 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
          end else if (din_vld) begin
            dec_cnt <= (dec_cnt == decim_q) ? '0 : dec_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= din;
  end
endmodule

// File: tb/tb_fir_capture.sv
// Randomized and directed bench for fir_capture against a queue-based reference model.
module tb_fir_capture;
  localparam int DW     = 10;
  localparam int DEPTH  = 8;
  localparam int WARMUP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic [2:0]    decim;
  logic          din_vld;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          dout_rdy;
  logic [3:0]    level;
  logic          busy;
  logic          ovf;

  fir_capture #(.DW(DW), .DEPTH(DEPTH), .WARMUP(WARMUP)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .decim(decim),
    .din_vld(din_vld), .din(din), .dout(dout), .dout_vld(dout_vld),
    .dout_rdy(dout_rdy), .level(level), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned fails = 0;

  // Reference model: capture armed flag, samples still to discard, candidate index.
  logic [DW-1:0] q[$];
  bit            armed;
  int            warm_left;
  int            cand;
  int            m_decim;
  bit            m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    armed = 0; warm_left = 0; cand = 0; m_decim = 0; m_ovf = 0;
  endtask

  task automatic model_edge();
    bit do_pop;
    int sz;
    sz = q.size();
    do_pop = (sz != 0) && dout_rdy;
    if (do_pop) void'(q.pop_front());
    if (armed && stop) begin
      armed = 0;
    end else if (!armed && start) begin
      armed = 1; warm_left = WARMUP; cand = 0; m_decim = int'(decim); m_ovf = 0;
    end else if (armed && din_vld) begin
      if (warm_left > 0) begin
        warm_left--;
      end else begin
        if (cand % (m_decim + 1) == 0) begin
          if (sz < DEPTH || do_pop) q.push_back(din);
          else m_ovf = 1;
        end
        cand++;
      end
    end
  endtask

  task automatic compare_all();
    check("level", 32'(level), 32'(q.size()));
    check("dout_vld", 32'(dout_vld), 32'(q.size() != 0));
    check("dout", 32'(dout), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    check("busy", 32'(busy), 32'(armed));
    check("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; din_vld = 0; din = '0; dout_rdy = 0;
  endtask

  task automatic do_start(input logic [2:0] d);
    start = 1; decim = d; step(); start = 0;
  endtask

  task automatic do_stop();
    stop = 1; step(); stop = 0;
  endtask

  // Feed n consecutive samples valued first, first+1, ...
  task automatic feed(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      din_vld = 1; din = DW'(first + i); step();
    end
    din_vld = 0;
  endtask

  task automatic drain_expect(input string tag, input int n, input int first, input int stride);
    dout_rdy = 1;
    for (int i = 0; i < n; i++) begin
      check(tag, 32'(dout), 32'(first + i * stride));
      step();
    end
    dout_rdy = 0;
  endtask

  initial begin
    idle_inputs();
    decim = '0;
    rst = 1;
    model_reset();
    #1;
    check("reset_level", 32'(level), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Warm-up with decim=0: first kept sample is 5.
    dout_rdy = 1;
    do_start(3'd0);
    check("busy_rise", 32'(busy), 32'd1);
    feed(5, 1);
    check("first_kept", 32'(dout), 32'd5);
    feed(10, 6);
    do_stop();
    check("busy_fall", 32'(busy), 32'd0);
    repeat (3) step();

    // Decimation by 3: kept 5, 8, 11.
    dout_rdy = 0;
    do_start(3'd2);
    feed(13, 1);
    check("decim_level", 32'(level), 32'd3);
    do_stop();
    drain_expect("decim_seq", 3, 5, 3);

    // Overflow: 14 inputs, 10 candidates, 8 stored.
    do_start(3'd0);
    feed(14, 1);
    check("ovf_level", 32'(level), 32'd8);
    check("ovf_set", 32'(ovf), 32'd1);
    do_stop();
    drain_expect("ovf_drain", 8, 5, 1);
    check("ovf_sticky", 32'(ovf), 32'd1);
    do_start(3'd0);
    check("ovf_cleared", 32'(ovf), 32'd0);
    do_stop();

    // Full FIFO with simultaneous push and pop.
    do_start(3'd0);
    feed(12, 1);
    check("full_level", 32'(level), 32'd8);
    dout_rdy = 1;
    feed(5, 13);
    check("full_pp_level", 32'(level), 32'd8);
    check("full_pp_ovf", 32'(ovf), 32'd0);
    check("full_pp_head", 32'(dout), 32'd10);
    do_stop();
    dout_rdy = 1;
    repeat (10) step();

    // Stop during warm-up, then restart discards four fresh samples.
    dout_rdy = 0;
    do_start(3'd0);
    feed(2, 100);
    do_stop();
    check("warm_stop_level", 32'(level), 32'd0);
    check("warm_stop_busy", 32'(busy), 32'd0);
    do_start(3'd0);
    feed(4, 200);
    check("rewarm_empty", 32'(level), 32'd0);
    feed(1, 300);
    check("rewarm_head", 32'(dout), 32'd300);

    // Asynchronous reset mid-stream, between clock edges.
    din_vld = 1; din = 10'd7;
    #2 rst = 1;
    #1;
    model_reset();
    check("arst_level", 32'(level), 32'd0);
    check("arst_vld", 32'(dout_vld), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ovf", 32'(ovf), 32'd0);
    idle_inputs();
    @(posedge clk);
    #1 rst = 0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 19) == 0);
      stop     = ($urandom_range(0, 49) == 0);
      decim    = 3'($urandom_range(0, 7));
      din_vld  = ($urandom_range(0, 3) != 0);
      din      = DW'($urandom);
      dout_rdy = ($urandom_range(0, 9) < 6);
      step();
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/fir_capture.md
# fir_capture

Output-side capture buffer for the FIR filter's 10-bit sample stream. It discards the filter's pipeline warm-up samples, optionally decimates the stream, and buffers kept samples in a small FIFO. Samples drain over a valid/ready handshake to the downstream consumer (bus reader or serializer). It sits directly after the filter and is the reader for the filter's output stream.

## Interface
- DW, 10, sample width; matches filter output width.
- DEPTH, 8, FIFO depth in samples; must be a power of 2, at least 2.
- WARMUP, 4, number of accepted input samples discarded after start; equals the filter's delay-line length.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle pulse; arms a capture.
- stop  in  1  one-cycle pulse; ends a capture.
- decim  in  3  decimation; keep 1 of every decim+1 samples; latched at start.
- din_vld  in  1  input sample strobe.
- din  in  DW  filter output sample.
- dout  out  DW  FIFO head sample.
- dout_vld  out  1  FIFO not empty.
- dout_rdy  in  1  consumer accepts dout this cycle.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- busy  out  1  high in WARM or RUN.
- ovf  out  1  sticky overflow flag.

## Operation
- FSM states: IDLE, WARM, RUN.
- IDLE -> WARM on start. Actions on this transition:
  - latch decim;
  - clear the warm-up counter and ovf.
- WARM: each din_vld increments the warm-up counter and the sample is discarded. After the WARMUP-th sample, go to RUN and clear the decimation counter to 0.
- RUN: each din_vld is a candidate.
  - When the decimation counter is 0, push din.
  - The counter then increments and wraps to 0 after reaching the latched decim value. With decim=0, every sample is kept.
- stop in WARM or RUN -> IDLE. Any din_vld in the same cycle is not pushed. FIFO contents are kept and continue draining.
- start while busy: ignored. stop in IDLE: ignored. start and stop in the same cycle: stop wins if busy; start wins if IDLE.
- FIFO push rules:
  - A push is accepted if level < DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the sample is dropped and ovf is set. ovf stays set until the next IDLE -> WARM transition or reset.
- FIFO pop occurs when dout_vld && dout_rdy. A pop on an empty FIFO is impossible, because dout_vld is low.
- Ordering is strict FIFO. The read and write pointers wrap modulo DEPTH.
- level changes each cycle: +1 on push only, -1 on pop only, unchanged on both or neither.

## Timing
- Reset (asynchronous, effective immediately):
  - state IDLE; FIFO empty; level=0;
  - dout_vld=0, dout=0, busy=0, ovf=0;
  - decimation and warm-up counters = 0.
- busy rises the cycle after start is sampled and falls the cycle after stop is sampled.
- Push latency: a sample pushed at edge N is visible on dout with dout_vld=1 after edge N, when the FIFO was empty.
- dout holds stable while dout_vld=1 and dout_rdy=0.
- Sustained throughput is 1 sample/cycle in and out.
- level and ovf are registered and update on the same edge as the push or drop.
- din_vld=0 cycles advance no counter.

## Test plan
- Reset: assert rst mid-stream -> level=0, dout_vld=0, busy=0, ovf=0 immediately, with no clock edge required.
- Warm-up, decim=0:
  - stimulus: start, then din_vld=1 every cycle with din=1,2,3,...; dout_rdy=1;
  - required: dout sequence 5,6,7,8...; ovf=0.
- Decimation, decim=2:
  - stimulus: same input stream as above;
  - required: dout sequence 5,8,11,14...
- Overflow:
  - stimulus: dout_rdy=0, decim=0, 14 input samples;
  - required: level=8, ovf=1; drain yields 5..12; next start clears ovf to 0.
- Full with simultaneous push and pop: fill to 8, then dout_rdy=1 with din_vld=1 -> level stays 8, ovf=0, no sample lost.
- Stop during WARM after 2 samples -> IDLE, level=0. A following start -> four fresh warm-up samples are discarded again.
